// File: rtl/cache_ctrl_param.sv
// Parametrised 1- or 2-way write-back cache controller with true-LRU replacement,
// a CPU request/ready handshake and a block-wide memory request/ack handshake.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for cpuReq; request fields latched on acceptance
// COMPARE   | tag lookup; hit completes, miss picks a victim
// WRITEBACK | dirty victim line being written to memory
// ALLOCATE  | requested line being filled from memory, then re-compare
module cache_ctrl_param #(
   parameter int ADDR_WIDTH  = 10,
   parameter int WORD_WIDTH  = 32,
   parameter int BLOCK_WORDS = 4,
   parameter int NUM_SETS    = 4,
   parameter int ASSOC       = 2
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              cpuReq,
   input  logic                              isRead,
   input  logic [ADDR_WIDTH-1:0]             address,
   input  logic [WORD_WIDTH-1:0]             writeData,
   output logic [WORD_WIDTH-1:0]             readData,
   output logic                              isHit,
   output logic                              cpuReady,
   output logic                              busy,
   output logic                              memReq,
   output logic                              memWrite,
   output logic [ADDR_WIDTH-1:0]             memAddress,
   output logic [BLOCK_WORDS*WORD_WIDTH-1:0] memWriteData,
   input  logic [BLOCK_WORDS*WORD_WIDTH-1:0] memReadData,
   input  logic                              memAck
);

   localparam int BYTE_W = $clog2(WORD_WIDTH / 8);
   localparam int WORD_W = $clog2(BLOCK_WORDS);
   localparam int OFF_W  = BYTE_W + WORD_W;
   localparam int IDX_W  = $clog2(NUM_SETS);
   localparam int TAG_W  = ADDR_WIDTH - OFF_W - IDX_W;
   localparam int LINE_W = BLOCK_WORDS * WORD_WIDTH;

   typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

   state_t state, state_next;

   // Storage is always two ways deep; way 1 is never hit or chosen when ASSOC=1.
   logic [NUM_SETS-1:0] valid [2];
   logic [NUM_SETS-1:0] dirty [2];
   logic [TAG_W-1:0]    tags  [2][NUM_SETS];
   logic [LINE_W-1:0]   lines [2][NUM_SETS];
   logic [NUM_SETS-1:0] lru;

   logic                  req_read;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [WORD_WIDTH-1:0] req_wdata;
   logic                  miss_flag;
   logic                  victim;

   logic [TAG_W-1:0]      req_tag;
   logic [IDX_W-1:0]      req_idx;
   logic [WORD_W-1:0]     req_word;
   logic                  unused_bits;

   logic                  hit0, hit1, hit, hit_way, victim_sel;
   logic [WORD_WIDTH-1:0] hit_word;

   assign req_tag     = req_addr[ADDR_WIDTH-1 -: TAG_W];
   assign req_idx     = req_addr[OFF_W +: IDX_W];
   assign req_word    = req_addr[BYTE_W +: WORD_W];
   assign unused_bits = ^req_addr[BYTE_W-1:0];
   assign busy        = (state != IDLE);

   always_comb begin
      hit0     = valid[0][req_idx] && (tags[0][req_idx] == req_tag);
      hit1     = (ASSOC == 2) && valid[1][req_idx] && (tags[1][req_idx] == req_tag);
      hit      = hit0 || hit1;
      hit_way  = !hit0;
      hit_word = lines[hit_way][req_idx][req_word*WORD_WIDTH +: WORD_WIDTH];
      if (ASSOC == 1)
         victim_sel = 1'b0;
      else if (!valid[0][req_idx])
         victim_sel = 1'b0;
      else if (!valid[1][req_idx])
         victim_sel = 1'b1;
      else
         victim_sel = lru[req_idx];
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next   = state;
      memReq       = 1'b0;
      memWrite     = 1'b0;
      memAddress   = '0;
      memWriteData = '0;
      case (state)
         IDLE: begin
            if (cpuReq)
               state_next = COMPARE;
         end
         COMPARE: begin
            if (hit)
               state_next = IDLE;
            else if (valid[victim_sel][req_idx] && dirty[victim_sel][req_idx])
               state_next = WRITEBACK;
            else
               state_next = ALLOCATE;
         end
         WRITEBACK: begin
            memReq       = 1'b1;
            memWrite     = 1'b1;
            memAddress   = {tags[victim][req_idx], req_idx, {OFF_W{1'b0}}};
            memWriteData = lines[victim][req_idx];
            if (memAck)
               state_next = ALLOCATE;
         end
         ALLOCATE: begin
            memReq     = 1'b1;
            memAddress = {req_tag, req_idx, {OFF_W{1'b0}}};
            if (memAck)
               state_next = COMPARE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid[0]  <= '0;
         valid[1]  <= '0;
         dirty[0]  <= '0;
         dirty[1]  <= '0;
         lru       <= '0;
         req_read  <= 1'b0;
         req_addr  <= '0;
         req_wdata <= '0;
         miss_flag <= 1'b0;
         victim    <= 1'b0;
         readData  <= '0;
         isHit     <= 1'b0;
         cpuReady  <= 1'b0;
      end else begin
         cpuReady <= 1'b0;
         case (state)
            IDLE: begin
               if (cpuReq) begin
                  req_read  <= isRead;
                  req_addr  <= address;
                  req_wdata <= writeData;
                  miss_flag <= 1'b0;
               end
            end
            COMPARE: begin
               if (hit) begin
                  if (req_read) begin
                     readData <= hit_word;
                  end else begin
                     readData <= '0;
                     lines[hit_way][req_idx][req_word*WORD_WIDTH +: WORD_WIDTH] <= req_wdata;
                     dirty[hit_way][req_idx] <= 1'b1;
                  end
                  lru[req_idx] <= ~hit_way;
                  isHit        <= !miss_flag;
                  cpuReady     <= 1'b1;
               end else begin
                  miss_flag <= 1'b1;
                  victim    <= victim_sel;
               end
            end
            WRITEBACK: begin
               if (memAck)
                  dirty[victim][req_idx] <= 1'b0;
            end
            ALLOCATE: begin
               if (memAck) begin
                  lines[victim][req_idx] <= memReadData;
                  tags[victim][req_idx]  <= req_tag;
                  valid[victim][req_idx] <= 1'b1;
                  dirty[victim][req_idx] <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/cache_ctrl_param.md
Name: cache_ctrl_param

Overview:
- Clocked, parametrised cache controller; successor to the fixed 1a cache-plus-memory data path.
- Generalised in address/word width, block size, set count and associativity (1- or 2-way).
- Adds write-back with dirty bits, true-LRU replacement, a CPU request/ready handshake and a memory request/acknowledge handshake with arbitrary memory latency.
- Sits between the CPU-side data bus and the block-wide memory model.

Parameters:
ADDR_WIDTH, 10, byte address width
WORD_WIDTH, 32, CPU word width (multiple of 8)
BLOCK_WORDS, 4, words per line (power of 2); memory bus is BLOCK_WORDS*WORD_WIDTH bits
NUM_SETS, 4, number of sets (power of 2)
ASSOC, 2, ways per set; legal values 1 or 2

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
cpuReq  input  1  request strobe, sampled only in IDLE
isRead  input  1  1 = read, 0 = write; latched with cpuReq
address  input  ADDR_WIDTH  byte address; latched with cpuReq
writeData  input  WORD_WIDTH  write word; latched with cpuReq
readData  output  WORD_WIDTH  read result, valid while cpuReady=1
isHit  output  1  1 if the request hit on first lookup, valid while cpuReady=1
cpuReady  output  1  one-cycle completion pulse
busy  output  1  high whenever state != IDLE
memReq  output  1  memory transaction request
memWrite  output  1  1 = block write-back, 0 = block fill
memAddress  output  ADDR_WIDTH  block-aligned byte address (offset bits 0)
memWriteData  output  BLOCK_WORDS*WORD_WIDTH  victim line, word 0 in LSBs
memReadData  input  BLOCK_WORDS*WORD_WIDTH  fill line, word 0 in LSBs
memAck  input  1  one-cycle pulse completing the current memory transaction

Behaviour:
- Address split (LSB first):
  - byte offset: log2(WORD_WIDTH/8)
  - word offset: log2(BLOCK_WORDS)
  - index: log2(NUM_SETS)
  - tag: remaining bits
  - Defaults: [1:0] byte, [3:2] word, [5:4] index, [9:6] tag.
- Per-way line state: valid, dirty, tag, data. Per-set state: lru bit, which names the least-recently-used way (unused when ASSOC=1).
- Reset: all valid, dirty and lru bits = 0; state = IDLE. Outputs readData=0, isHit=0, cpuReady=0, busy=0, memReq=0, memWrite=0, memAddress=0, memWriteData=0.
- FSM states: IDLE, COMPARE, WRITEBACK, ALLOCATE.
- IDLE: on cpuReq=1, latch isRead/address/writeData, clear missFlag, go to COMPARE. cpuReq in any other state is ignored and is not queued.
- COMPARE, hit (valid and tag match in way w):
  - read: readData <= selected word.
  - write: merge writeData into the word, set dirty=1, readData <= 0.
  - Set lru <= ~w, isHit <= !missFlag, cpuReady <= 1 for exactly one cycle, go to IDLE.
- COMPARE, miss:
  - Set missFlag.
  - Victim selection: the lowest-numbered invalid way; if none is invalid, the lru way; always way 0 when ASSOC=1.
  - If the victim is valid and dirty, go to WRITEBACK; otherwise go to ALLOCATE.
- WRITEBACK: memReq=1, memWrite=1, memAddress = {victim tag, index, 0}, memWriteData = victim line. On memAck: clear victim dirty, go to ALLOCATE.
- ALLOCATE: memReq=1, memWrite=0, memAddress = {req tag, index, 0}. On memAck: write memReadData into the victim, set valid=1, dirty=0, tag = req tag, go to COMPARE. The retry hits, so isHit reports 0 via missFlag.
- memReq, memWrite, memAddress and memWriteData are decoded from state and held stable until memAck. A transaction boundary is marked by the state change after memAck.
- The memory must not assert memAck in the cycle immediately after a prior memAck. memAck outside WRITEBACK/ALLOCATE is ignored.
- Latency:
  - Hit: cpuReady is high 2 cycles after the cpuReq sampling edge.
  - Clean miss: 3 + fill latency.
  - Dirty miss: additionally + write-back latency.
- Reset asserted mid-operation (any state): next cycle is IDLE with memReq=0; all lines are invalidated and dirty data is lost; no cpuReady is issued for the aborted request.

Test Plan:
- Reset, read 0x004, memory returns line {0x33333333,0x22222222,0x11111111,0x00000000} after a 3-cycle ack -> memReq with memWrite=0, memAddress=0x000; then cpuReady with readData=0x11111111, isHit=0.
- Then read 0x008 -> no memReq; cpuReady 2 cycles after request; readData=0x22222222, isHit=1.
- Write 0x00C=0xDEADBEEF (hit), read 0x040 (miss, way1), read 0x080 -> victim way0: write-back to memAddress=0x000 with word3=0xDEADBEEF, then fill at 0x080; isHit=0.
- Clean conflict: read 0x000, 0x040, 0x000, 0x080 -> 0x040's way evicted; memWrite never 1; a following read 0x000 hits.
- Reset asserted 2 cycles into ALLOCATE -> memReq=0 next cycle, no cpuReady; re-read of the same address misses (memReq reasserted).
- cpuReq pulsed while busy, and memAck delayed 6 cycles -> memReq/memAddress held stable 6 cycles; the busy-time request produces no response; ASSOC=1 run: 0x000 then 0x040 both miss on set 0.
